capture_buffer: RTL

CAPTURE_BUFFER -- requirements
Module: capture_buffer

---
 rtl/capture_buffer.sv | 95 +++++++++
 1 files changed

// File: rtl/capture_buffer.sv
// capture_buffer: pre/post-trigger sample capture buffer with valid/ready chronological readout
// Ports: clk; rst_n (sync, active-low); arm, trigger (control); s_valid/s_data (sample input);
//        m_valid/m_data/m_last/m_ready (readout stream); busy, triggered (status).
module capture_buffer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trigger,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              triggered
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PRE = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] RD_LAST = AW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, ARMED, POST, READOUT} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_pre_cnt, r_post_cnt, r_rd_cnt;
  logic r_rd_done;
  logic w_wr, w_accept, w_load, w_fin;
  assign w_wr = (r_state == ARMED || r_state == POST) && s_valid;
  assign w_accept = r_state == ARMED && s_valid && trigger && r_pre_cnt == PRE;
  // output register refills whenever it is empty or being drained this cycle
  assign w_load = r_state == READOUT && !r_rd_done && (!m_valid || m_ready);
  assign w_fin = r_state == READOUT && m_valid && m_ready && m_last;
  assign busy = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = arm ? ARMED : IDLE;
      // with a single post-trigger sample the trigger sample completes the capture
      ARMED:   w_next = w_accept ? (POST_LAST == '0 ? READOUT : POST) : ARMED;
      POST:    w_next = s_valid && r_post_cnt == POST_LAST ? READOUT : POST;
      default: w_next = w_fin ? IDLE : READOUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= s_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_pre_cnt <= '0;
      r_post_cnt <= '0;
      r_rd_cnt <= '0;
      r_rd_done <= 1'b0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
      triggered <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == IDLE && arm) begin
        r_pre_cnt <= '0;
        r_rd_cnt <= '0;
        r_rd_done <= 1'b0;
      end
      if (r_state == ARMED && s_valid && r_pre_cnt != PRE) r_pre_cnt <= r_pre_cnt + 1'b1;
      // readout starts PRE_TRIG samples before the trigger sample's address
      if (w_accept) begin
        r_rd_ptr <= r_wr_ptr - PRE;
        r_post_cnt <= AW'(1);
        triggered <= 1'b1;
      end else if (r_state == POST && s_valid) r_post_cnt <= r_post_cnt + 1'b1;
      if (w_load) begin
        m_data <= r_mem[r_rd_ptr];
        m_valid <= 1'b1;
        m_last <= r_rd_cnt == RD_LAST;
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rd_cnt <= r_rd_cnt + 1'b1;
        r_rd_done <= r_rd_cnt == RD_LAST;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last <= 1'b0;
      end
      if (w_fin) triggered <= 1'b0;
    end
  end
endmodule
